// File: rtl/cmd_pkg.sv
// Shared types and sizes for the 2048x16 command ring.
// Used by both the ring writer and cmd_reader.
package cmd_pkg;

  localparam int CMD_ADDR_W = 11;
  localparam int CMD_DATA_W = 16;
  localparam int CMD_DEPTH  = 2048;

  typedef struct packed {
    logic [7:0] len;
    logic [7:0] sym_id;
  } cmd_hdr_t;

  typedef enum logic {
    ST_HDR,
    ST_PAYLOAD
  } rd_state_e;

  function automatic logic [7:0] hdr_len(
    input logic [CMD_DATA_W-1:0] w
  );
    cmd_hdr_t h;
    h = w;
    return h.len;
  endfunction

endpackage

// File: rtl/cmd_obuf.sv
// Small synchronous FIFO between the RAM read port and the
// command stream; dout reads as zero while empty.
module cmd_obuf
  import cmd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [CMD_DATA_W-1:0]   din,
  input  logic                    pop,
  output logic [CMD_DATA_W-1:0]   dout,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty
);

  localparam int AW = $clog2(DEPTH);

  logic [CMD_DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_q, wr_d;
  logic [AW-1:0]         rd_q, rd_d;
  logic [AW:0]           cnt_q, cnt_d;
  logic                  pop_ok;

  assign empty  = (cnt_q == '0);
  assign count  = cnt_q;
  assign pop_ok = pop && !empty;
  assign dout   = empty ? '0 : mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q + AW'(push);
    rd_d  = rd_q + AW'(pop_ok);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/cmd_reader.sv
// Command ring read engine: fetches words, frames header/payload.
// Optional CMD_COUNT port via CMD_READER_COUNT_EN.
module cmd_reader
  import cmd_pkg::*;
#(
  parameter int OBUF_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [CMD_ADDR_W-1:0] WR_PTR,
  output logic [CMD_ADDR_W-1:0] RD_PTR,
  output logic                  RE,
  output logic [CMD_ADDR_W-1:0] RADDR,
  input  logic [CMD_DATA_W-1:0] RDATA,
  output logic                  CMD_VALID,
  input  logic                  CMD_READY,
  output logic [CMD_DATA_W-1:0] CMD_DATA,
`ifdef CMD_READER_COUNT_EN
  output logic                  CMD_LAST,
  output logic [15:0]           CMD_COUNT
`else
  output logic                  CMD_LAST
`endif
);

  localparam int CW = $clog2(OBUF_DEPTH) + 1;

  logic [CMD_ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic                  inflight_q, inflight_d;
  rd_state_e             state_q, state_d;
  logic [7:0]            rem_q, rem_d;
  logic [CW-1:0]         ob_count;
  logic [CW-1:0]         occ;
  logic                  ob_empty;
  logic [CMD_DATA_W-1:0] ob_dout;
  logic                  fetch, pop, last;

  cmd_obuf #(
    .DEPTH (OBUF_DEPTH)
  ) u_obuf (
    .clk   (CLK),
    .rst   (RST),
    .push  (inflight_q),
    .din   (RDATA),
    .pop   (pop),
    .dout  (ob_dout),
    .count (ob_count),
    .empty (ob_empty)
  );

  // inflight word already owns a slot, so count it as occupancy
  assign occ   = ob_count + CW'(inflight_q);
  assign fetch = (rd_ptr_q != WR_PTR) && (occ < CW'(OBUF_DEPTH));
  assign pop   = !ob_empty && CMD_READY;

  assign RD_PTR    = rd_ptr_q;
  assign RADDR     = rd_ptr_q;
  assign RE        = fetch;
  assign CMD_VALID = !ob_empty;
  assign CMD_DATA  = ob_dout;
  assign CMD_LAST  = !ob_empty && last;

  always_comb begin
    rd_ptr_d   = rd_ptr_q + CMD_ADDR_W'(fetch);
    inflight_d = fetch;
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    last    = 1'b0;
    unique case (state_q)
      ST_HDR: begin
        last = (hdr_len(ob_dout) == 8'd0);
        if (pop && !last) begin
          rem_d   = hdr_len(ob_dout);
          state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        last = (rem_q == 8'd1);
        if (pop) begin
          rem_d = rem_q - 8'd1;
          if (last) state_d = ST_HDR;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
      state_q    <= ST_HDR;
      rem_q      <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
      state_q    <= state_d;
      rem_q      <= rem_d;
    end
  end

`ifdef CMD_READER_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  assign CMD_COUNT = cnt_q;

  always_comb begin
    cnt_d = cnt_q + 16'(pop && last);
  end

  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`endif

endmodule

// File: tb/tb_cmd_reader.sv
// Bench for cmd_reader: ring RAM model, message-level scoreboard,
// directed test-plan scenarios plus randomized traffic.
module tb_cmd_reader;
  import cmd_pkg::*;

  localparam int OD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] wr_ptr = '0;
  logic [10:0] rd_ptr, raddr;
  logic        re;
  logic [15:0] rdata = '0;
  logic        v, last;
  logic        rdy = 1'b1;
  logic [15:0] data;
`ifdef CMD_READER_COUNT_EN
  logic [15:0] cnt;
`endif

  cmd_reader #(.OBUF_DEPTH(OD)) dut (
    .CLK       (clk),
    .RST       (rst),
    .WR_PTR    (wr_ptr),
    .RD_PTR    (rd_ptr),
    .RE        (re),
    .RADDR     (raddr),
    .RDATA     (rdata),
    .CMD_VALID (v),
    .CMD_READY (rdy),
    .CMD_DATA  (data),
`ifdef CMD_READER_COUNT_EN
    .CMD_LAST  (last),
    .CMD_COUNT (cnt)
`else
    .CMD_LAST  (last)
`endif
  );

  always #5 clk = ~clk;

  logic [15:0] mem [2048];
  always @(posedge clk) if (re) rdata <= mem[raddr];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  typedef struct {
    logic [15:0] d;
    logic        l;
  } exp_t;

  exp_t        exp_q[$];
  logic [10:0] pop_addr = '0;
  logic [10:0] wp = '0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data = '0;
  int          exp_cnt = 0;
  int          max_occ = 0;
  int          rdy_mode = 0;
  int          ph = 0;

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      1:       rdy = 1'($urandom_range(0, 1));
      2:       begin rdy = (ph % 3 == 0); ph++; end
      default: rdy = 1'b1;
    endcase
  end

  // scoreboard: occupancy = words fetched but not yet consumed
  always @(negedge clk) begin
    logic [10:0] occ;
    exp_t e;
    if (rst) begin
      pop_addr   = '0;
      exp_q.delete();
      prev_stall = 1'b0;
      exp_cnt    = 0;
    end else begin
      occ = 11'(rd_ptr - pop_addr);
      if (int'(occ) > max_occ) max_occ = int'(occ);
      check("re", re, (rd_ptr != wr_ptr) && (occ < 11'(OD)));
      check("raddr", raddr, rd_ptr);
      if (prev_stall) begin
        check("stall_valid", v, 1);
        check("stall_data", data, prev_data);
      end
      if (v && rdy) begin
        if (exp_q.size() == 0) begin
          check("extra_pop", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("data", data, e.d);
          check("last", last, e.l);
`ifdef CMD_READER_COUNT_EN
          check("count", cnt, 32'(16'(exp_cnt)));
          if (e.l) exp_cnt++;
`endif
        end
        pop_addr++;
      end
      prev_stall = v && !rdy;
      prev_data  = data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic put_word(input logic [15:0] w, input logic l);
    exp_t e;
    mem[wp] = w;
    e.d = w;
    e.l = l;
    exp_q.push_back(e);
    wp++;
  endtask

  task automatic put_msg(input logic [7:0] id, input int n);
    put_word({8'(n), id}, n == 0);
    for (int k = 1; k <= n; k++) put_word(16'($urandom), k == n);
  endtask

  task automatic drain(input int maxc);
    int c = 0;
    while ((exp_q.size() != 0 || rd_ptr != wr_ptr) && c < maxc) begin
      tick();
      c++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic check_reset_vals();
    check("rst_rd_ptr", rd_ptr, 0);
    check("rst_re", re, 0);
    check("rst_raddr", raddr, 0);
    check("rst_valid", v, 0);
    check("rst_data", data, 0);
    check("rst_last", last, 0);
`ifdef CMD_READER_COUNT_EN
    check("rst_count", cnt, 0);
`endif
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    wr_ptr = '0;
    wp     = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_reset_vals();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int step;
`ifdef CMD_READER_COUNT_EN
    logic [15:0] c0;
`endif
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    do_reset();

    // single command, latency and back-to-back words
    put_word(16'h0305, 1'b0);
    put_word(16'hAAAA, 1'b0);
    put_word(16'hBBBB, 1'b0);
    put_word(16'hCCCC, 1'b1);
    wr_ptr = wp;
    #1;
    check("lat_re_t", re, 1);
    check("lat_valid_t", v, 0);
    tick(); #1;
    check("lat_valid_t1", v, 0);
    tick(); #1;
    check("lat_valid_t2", v, 1);
    check("lat_data_t2", data, 16'h0305);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      check("burst_valid", v, 1);
    end
    tick(); #1;
    check("burst_end", v, 0);
    check("single_rd_ptr", rd_ptr, 4);

    // zero-length then one-word message
    put_word(16'h0009, 1'b1);
    put_word(16'h0107, 1'b0);
    put_word(16'h1234, 1'b1);
    wr_ptr = wp;
    drain(100);
    check("zero_rd_ptr", rd_ptr, 7);

    // backpressure 1,0,0 on a 10-word message
    max_occ  = 0;
    ph       = 0;
    rdy_mode = 2;
    put_msg(8'h22, 9);
    wr_ptr = wp;
    drain(200);
    check("bp_max_occ", max_occ, OD);
    rdy_mode = 0;

    // partial message with a 20-cycle gap
`ifdef CMD_READER_COUNT_EN
    c0 = cnt;
`endif
    put_word(16'h0233, 1'b0);
    put_word(16'h1111, 1'b0);
    wr_ptr = wp;
    repeat (20) tick();
    #1;
    check("partial_gap_valid", v, 0);
    put_word(16'h2222, 1'b1);
    wr_ptr = wp;
    drain(100);
`ifdef CMD_READER_COUNT_EN
    check("partial_count", cnt, 16'(c0 + 16'd1));
`endif

    // randomized traffic with chunked pointer updates
    for (int b = 0; b < 8; b++) begin
      rdy_mode = 1;
      for (int m = 0; m < int'($urandom_range(1, 4)); m++)
        put_msg(8'($urandom), int'($urandom_range(0, 12)));
      while (wr_ptr != wp) begin
        step = int'($urandom_range(1, 5));
        if (int'(11'(wp - wr_ptr)) < step) wr_ptr = wp;
        else wr_ptr = wr_ptr + 11'(step);
        repeat (int'($urandom_range(0, 3))) tick();
        tick();
      end
      drain(1000);
    end
    rdy_mode = 0;

    // wrap: advance the ring to 2046, then a message across 0
    do_reset();
    for (int i = 0; i < 7; i++) put_msg(8'(i), 255);
    put_msg(8'h77, 253);
    wr_ptr = wp;
    drain(3000);
    check("wrap_pre_ptr", rd_ptr, 2046);
    put_word(16'h0301, 1'b0);
    put_word(16'hD001, 1'b0);
    put_word(16'hD002, 1'b0);
    put_word(16'hD003, 1'b1);
    wr_ptr = wp;
    drain(100);
    check("wrap_rd_ptr", rd_ptr, 2);

    // reset while PAYLOAD with two words remaining
    do_reset();
    put_word(16'h0444, 1'b0);
    put_word(16'h0A0A, 1'b0);
    put_word(16'h0B0B, 1'b0);
    wr_ptr = wp;
    drain(100);
    rst    = 1'b1;
    wr_ptr = '0;
    wp     = '0;
    tick();
    rst = 1'b0;
    #1;
    check_reset_vals();
    put_word(16'h0111, 1'b0);
    put_word(16'h5555, 1'b1);
    wr_ptr = wp;
    drain(100);
    check("post_rst_ptr", rd_ptr, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
